adc_spi_scanner: RTL and testbench
==================================

// Module: adc_spi_scanner
// PURPOSE
//  Parametrised SPI master for serial 8-ch ADCs (ADC128S022-class) feeding the scope front end.
//  Generates SCLK from a clk divider instead of gating a raw clock.
//  Scans a channel mask round-robin and returns channel-tagged samples with a one-cycle valid strobe.
//  Supports continuous and single-pass modes.
// PARAMETERS
//  DATA_W    12  conversion result width
//  ADDR_W    3   channel address width; NUM_CH = 2**ADDR_W
//  FRAME_LEN 16  SCLK periods per CS-low frame; must be >= ADDR_POS+ADDR_W and >= DATA_W
//  ADDR_POS  2   SCLK period index (0-based) where the address MSB is driven
//  CLK_DIV   2   clk cycles per SCLK half-period (>=1)
//  QUIET     2   clk cycles CS held high between frames (>=1)
// PORTS
//  clk          in  1         system clock
//  Resetn       in  1         synchronous reset, active-HIGH despite the name
//  start        in  1         level; begin scanning when in IDLE
//  stop         in  1         level; finish current frame, then go to IDLE
//  single       in  1         1 = one pass over mask then IDLE; 0 = continuous
//  ch_mask      in  2**ADDR_W enabled channels; sampled at each frame start
//  ADC2SPI      in  1         ADC DOUT
//  sclk         out 1         SPI clock; idle high
//  cs           out 1         chip select; active low
//  din          out 1         ADC DIN (address)
//  ADC2Sseg     out DATA_W    last sample
//  sample_ch    out ADDR_W    channel of ADC2Sseg
//  sample_valid out 1         1-cycle strobe; ADC2Sseg/sample_ch updated in the same cycle
//  busy         out 1         1 whenever state != IDLE
//  done         out 1         1-cycle strobe at end of a single-mode pass
// BEHAVIOUR
//  Reset: cs=1, sclk=1, din=0, ADC2Sseg=0, sample_ch=0, sample_valid=0, busy=0, done=0.
//   Scan pointer = 0 and priming flag set.
//   A mid-frame reset forces cs/sclk high on the next edge and discards the partial sample.
//  FSM IDLE -> SETUP -> SHIFT -> GAP -> (SETUP | IDLE).
//   IDLE: when start=1 and ch_mask!=0, go to SETUP the next cycle.
//         start with ch_mask==0 is ignored.
//   SETUP: cs=0, sclk=1 for CLK_DIV cycles.
//   SHIFT: FRAME_LEN periods, each CLK_DIV low then CLK_DIV high. din changes only on entry to the low phase.
//     Period k in ADDR_POS..ADDR_POS+ADDR_W-1 drives addr[ADDR_POS+ADDR_W-1-k] (MSB first); other periods drive 0.
//     ADC2SPI is sampled on the clk where sclk goes 0->1, for k in FRAME_LEN-DATA_W..FRAME_LEN-1, MSB first.
//   GAP: cs=1, sclk=1 for QUIET cycles; the sample is published on the first GAP cycle.
//  Frame length = CLK_DIV + 2*CLK_DIV*FRAME_LEN + QUIET clks.
//  Pipelining: a frame returns the conversion of the address sent in the previous frame.
//   sample_ch = address of the previous frame.
//   The first frame after IDLE is a priming frame: sample_valid is suppressed.
//  Channel select: addr = next set bit of ch_mask at or after the scan pointer, wrapping from NUM_CH-1 to 0.
//   The pointer advances to addr+1 mod NUM_CH after each frame.
//  Mask change mid-scan takes effect at the next SETUP. If the mask becomes 0, finish the frame and go to IDLE.
//  Single mode: frames = popcount(mask)+1 (priming). done and the last sample_valid strobe in the same cycle; then IDLE.
//  End of GAP: if stop=1 go to IDLE; else go to SETUP (continuous). stop has priority over start.
//   stop during SETUP/SHIFT completes the frame and its sample.
//  Counters saturate nowhere. The bit counter wraps only via the FSM, with no modulo-16 aliasing.
// STRUCTURE
//  Shared package adc_spi_pkg: FSM state encoding, default DATA_W/ADDR_W/FRAME_LEN constants.
//  Sub-module adc_ch_picker: combinational next-enabled-channel search (mask, pointer -> addr, any).
//  Everything else (divider, bit counter, shift registers, FSM) lives in one always block set.
// TESTING
//  1. Defaults, mask=8'b0000_0101, single=1, ADC model returns 12'hA00+ch.
//     Expect 3 frames of 68 clks: no valid, then {ch0,A00}, then {ch2,A02} with done.
//  2. Continuous, mask=8'h80: din pattern 1,1,1 at periods 2..4 every frame.
//     Expect valid every 68 clks, sample_ch=7.
//  3. start with mask=0: busy stays 0, cs stays 1 for 200 clks.
//  4. stop asserted mid-SHIFT of frame 3: frame completes, valid issued, IDLE; no further cs-low.
//  5. Resetn pulsed at SCLK period 8: next cycle cs=1, sclk=1, no valid.
//     Restart begins with a priming frame.
//  6. CLK_DIV=1, FRAME_LEN=16, DATA_W=12: sclk period = 2 clks; ADC2SPI 12'h5A5 is captured exactly.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared definitions for the serial ADC scanner: FSM encoding and default geometry.
package adc_spi_pkg;

  localparam int DEF_DATA_W    = 12;
  localparam int DEF_ADDR_W    = 3;
  localparam int DEF_FRAME_LEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/adc_ch_picker.sv
// Combinational round-robin search: first enabled channel at or after ptr, wrapping.
module adc_ch_picker #(
  parameter int ADDR_W = 3
) (
  input  logic [(1<<ADDR_W)-1:0] mask,
  input  logic [ADDR_W-1:0]      ptr,
  output logic [ADDR_W-1:0]      addr,
  output logic                   any
);

  localparam int NUM_CH = 1 << ADDR_W;

  // Walk offsets from farthest to nearest so the nearest enabled channel wins.
  always_comb begin
    addr = ptr;
    any  = |mask;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[ptr + ADDR_W'(i)]) addr = ptr + ADDR_W'(i);
    end
  end

endmodule

// File: rtl/adc_spi_scanner.sv
// SPI master that scans an 8-channel serial ADC round-robin and returns channel-tagged samples.
module adc_spi_scanner
  import adc_spi_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int ADDR_POS  = 2,
  parameter int CLK_DIV   = 2,
  parameter int QUIET     = 2
) (
  input  logic                   clk,
  input  logic                   Resetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   single,
  input  logic [(1<<ADDR_W)-1:0] ch_mask,
  input  logic                   ADC2SPI,
  output logic                   sclk,
  output logic                   cs,
  output logic                   din,
  output logic [DATA_W-1:0]      ADC2Sseg,
  output logic [ADDR_W-1:0]      sample_ch,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_MAX = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_LEN + 1);
  localparam int LEFT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_LEN - 1);
  localparam logic [BIT_W-1:0] CAP_FIRST  = BIT_W'(FRAME_LEN - DATA_W);
  localparam logic [BIT_W-1:0] ADDR_FIRST = BIT_W'(ADDR_POS);
  localparam logic [BIT_W-1:0] ADDR_LAST  = BIT_W'(ADDR_POS + ADDR_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                phase_q, phase_d;   // 1 = high half of the current SCLK period
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   prev_q, prev_d;
  logic                prime_q, prime_d;
  logic                single_q, single_d;
  logic [LEFT_W-1:0]   left_q, left_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   ch_q, ch_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                cs_q, cs_d;
  logic                sclk_q, sclk_d;
  logic                din_q, din_d;
  logic                begin_frame;
  logic [ADDR_W-1:0]   pick_addr;
  logic                pick_any;

  adc_ch_picker #(.ADDR_W(ADDR_W)) u_pick (
    .mask (ch_mask),
    .ptr  (ptr_q),
    .addr (pick_addr),
    .any  (pick_any)
  );

  function automatic logic din_for(input logic [BIT_W-1:0] k, input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] idx;
    idx = ADDR_W'(ADDR_LAST - k);
    return (k >= ADDR_FIRST && k <= ADDR_LAST) ? a[idx] : 1'b0;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    prev_d      = prev_q;
    prime_d     = prime_q;
    single_d    = single_q;
    left_d      = left_q;
    sh_d        = sh_q;
    data_d      = data_q;
    ch_d        = ch_q;
    din_d       = din_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    begin_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        prime_d = 1'b1;
        if (start && !stop && pick_any) begin
          begin_frame = 1'b1;
          single_d    = single;
          left_d      = LEFT_W'($countones(ch_mask)) + LEFT_W'(1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          din_d   = din_for('0, addr_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (!phase_q) begin
            // The edge that raises SCLK is the one that captures DOUT.
            phase_d = 1'b1;
            if (bit_q >= CAP_FIRST) sh_d = {sh_q[DATA_W-2:0], ADC2SPI};
          end else if (bit_q != LAST_BIT) begin
            phase_d = 1'b0;
            bit_d   = bit_q + BIT_W'(1);
            din_d   = din_for(bit_q + BIT_W'(1), addr_q);
          end else begin
            state_d = ST_GAP;
            valid_d = !prime_q;
            done_d  = single_q && (left_q == LEFT_W'(1));
            prime_d = 1'b0;
            if (!prime_q) begin
              data_d = sh_q;
              ch_d   = prev_q;
            end
          end
        end
      end
      ST_GAP: begin
        if (cnt_q != QUIET_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (single_q) left_d = left_q - LEFT_W'(1);
          if (stop || !pick_any || (single_q && left_q == LEFT_W'(1))) state_d = ST_IDLE;
          else begin_frame = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Address is latched at frame start; this frame returns the previous frame's conversion.
    if (begin_frame) begin
      state_d = ST_SETUP;
      cnt_d   = '0;
      prev_d  = addr_q;
      addr_d  = pick_addr;
      ptr_d   = pick_addr + ADDR_W'(1);
    end

    cs_d   = !(state_d == ST_SETUP || state_d == ST_SHIFT);
    sclk_d = !(state_d == ST_SHIFT && !phase_d);
  end

  always_ff @(posedge clk) begin
    if (Resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      ptr_q    <= '0;
      addr_q   <= '0;
      prev_q   <= '0;
      prime_q  <= 1'b1;
      single_q <= 1'b0;
      left_q   <= '0;
      sh_q     <= '0;
      data_q   <= '0;
      ch_q     <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      prev_q   <= prev_d;
      prime_q  <= prime_d;
      single_q <= single_d;
      left_q   <= left_d;
      sh_q     <= sh_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
    end
  end

  assign sclk         = sclk_q;
  assign cs           = cs_q;
  assign din          = din_q;
  assign ADC2Sseg     = data_q;
  assign sample_ch    = ch_q;
  assign sample_valid = valid_q;
  assign done         = done_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_spi_scanner.sv
// Bench for adc_spi_scanner: behavioural ADC per instance, channel-order model and sample scoreboard.
module tb_adc_spi_scanner;

  localparam int FRAME_CLKS  = 68;   // 2 + 2*2*16 + 2
  localparam int PUB_OFS     = 66;   // cs-low cycle to first GAP cycle
  localparam int FRAME_CLKS2 = 35;   // 1 + 2*1*16 + 2
  localparam int PUB_OFS2    = 33;
  localparam int TMO         = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, single = 1'b0, adc_dout = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        sclk, cs, din, sample_valid, busy, done;
  logic [11:0] sample;
  logic [2:0]  sample_ch;

  logic        start2 = 1'b0, single2 = 1'b0, adc_dout2 = 1'b0;
  logic [7:0]  ch_mask2 = 8'h00;
  logic        sclk2, cs2, din2, sample_valid2, busy2, done2;
  logic [11:0] sample2;
  logic [2:0]  sample_ch2;

  adc_spi_scanner dut (
    .clk(clk), .Resetn(rst), .start(start), .stop(stop), .single(single),
    .ch_mask(ch_mask), .ADC2SPI(adc_dout), .sclk(sclk), .cs(cs), .din(din),
    .ADC2Sseg(sample), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .busy(busy), .done(done)
  );

  adc_spi_scanner #(.CLK_DIV(1)) dut2 (
    .clk(clk), .Resetn(rst), .start(start2), .stop(1'b0), .single(single2),
    .ch_mask(ch_mask2), .ADC2SPI(adc_dout2), .sclk(sclk2), .cs(cs2), .din(din2),
    .ADC2Sseg(sample2), .sample_ch(sample_ch2), .sample_valid(sample_valid2),
    .busy(busy2), .done(done2)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [11:0] conv [8];
  logic [2:0]  ref_ptr = 3'd0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          got_t[$];
  int          fall_t[$];
  logic [2:0]  dec_q[$];
  int          din_bad = 0;
  int          stray_done = 0;
  logic        cs_prev = 1'b1;

  logic [15:0] got2_q[$];
  int          got2_t[$];
  int          fall2_t[$];
  int          sclk2_rises = 0;
  logic        cs2_prev = 1'b1;
  logic        sclk2_prev = 1'b1;

  // ADC model: DOUT shifts on SCLK fall, DIN read on SCLK rise, result is for the previous frame's address.
  int          f_cnt = 0, r_cnt = 0;
  logic [11:0] cur_data = 12'h000;
  logic [2:0]  last_addr = 3'd0, dec_addr = 3'd0;

  always @(negedge cs) begin
    f_cnt = 0;
    r_cnt = 0;
    dec_addr = 3'd0;
    cur_data = conv[last_addr];
  end

  always @(negedge sclk) if (cs === 1'b0) begin
    adc_dout = (f_cnt >= 4 && f_cnt < 16) ? cur_data[4'(15 - f_cnt)] : 1'b0;
    f_cnt++;
  end

  always @(posedge sclk) if (cs === 1'b0) begin
    if (r_cnt >= 2 && r_cnt <= 4) dec_addr = {dec_addr[1:0], din};
    else if (din !== 1'b0) din_bad++;
    r_cnt++;
  end

  always @(posedge cs) if (r_cnt == 16) begin
    last_addr = dec_addr;
    dec_q.push_back(dec_addr);
  end

  int          f2_cnt = 0;
  logic [11:0] pattern2 = 12'h5A5;

  always @(negedge cs2) f2_cnt = 0;

  always @(negedge sclk2) if (cs2 === 1'b0) begin
    adc_dout2 = (f2_cnt >= 4 && f2_cnt < 16) ? pattern2[4'(15 - f2_cnt)] : 1'b0;
    f2_cnt++;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      got_q.push_back({done, sample_ch, sample});
      got_t.push_back(cyc);
    end
    if (done === 1'b1 && sample_valid !== 1'b1) stray_done++;
    if (cs_prev === 1'b1 && cs === 1'b0) fall_t.push_back(cyc);
    cs_prev = cs;
    if (sample_valid2 === 1'b1) begin
      got2_q.push_back({done2, sample_ch2, sample2});
      got2_t.push_back(cyc);
    end
    if (cs2_prev === 1'b1 && cs2 === 1'b0) fall2_t.push_back(cyc);
    if (sclk2_prev === 1'b0 && sclk2 === 1'b1) sclk2_rises++;
    cs2_prev = cs2;
    sclk2_prev = sclk2;
  end

  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] p);
    for (int i = 0; i < 8; i++) begin
      if (m[(int'(p) + i) % 8]) return 3'((int'(p) + i) % 8);
    end
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ref_ptr = 3'd0;
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs got=%b exp=1", cs); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got=%b exp=1", sclk); end
    checks++; if (din !== 1'b0) begin errors++; $display("FAIL reset_din got=%b exp=0", din); end
    checks++; if (sample !== 12'h000) begin errors++; $display("FAIL reset_data got=%h exp=000", sample); end
    checks++; if (sample_ch !== 3'd0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", sample_ch); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (cs2 !== 1'b1 || sclk2 !== 1'b1) begin errors++; $display("FAIL reset_dut2 got cs=%b sclk=%b exp 1 1", cs2, sclk2); end
  endtask

  task automatic test_scan(input string name, input logic [7:0] mask, input logic sgl,
                           input int stop_frame, input logic rnd);
    int         nframes, tmo;
    logic [2:0] exp_addr[$];
    logic [2:0] a;
    got_q.delete(); got_t.delete(); fall_t.delete(); dec_q.delete(); exp_q.delete();
    din_bad = 0;
    stray_done = 0;
    for (int c = 0; c < 8; c++) conv[c] = rnd ? 12'($urandom_range(0, 4095)) : 12'hA00 + 12'(c);
    nframes = sgl ? $countones(mask) + 1 : stop_frame;
    for (int i = 0; i < nframes; i++) begin
      a = next_ch(mask, ref_ptr);
      exp_addr.push_back(a);
      ref_ptr = a + 3'd1;
    end
    for (int i = 1; i < nframes; i++)
      exp_q.push_back({(sgl && i == nframes - 1), exp_addr[i-1], conv[exp_addr[i-1]]});

    @(negedge clk);
    ch_mask = mask;
    single = sgl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (stop_frame > 0) begin
      tmo = 0;
      while (fall_t.size() < stop_frame && tmo < TMO) begin @(negedge clk); tmo++; end
      repeat (30) @(negedge clk);
      stop = 1'b1;
    end
    tmo = 0;
    while (busy !== 1'b0 && tmo < TMO) begin @(negedge clk); tmo++; end
    checks++; if (tmo >= TMO) begin errors++; $display("FAIL %s idle_timeout busy=%b after %0d cycles", name, busy, tmo); end
    stop = 1'b0;
    repeat (150) @(negedge clk);

    checks++; if (fall_t.size() != nframes) begin errors++; $display("FAIL %s frame_count got=%0d exp=%0d", name, fall_t.size(), nframes); end
    for (int i = 1; i < fall_t.size(); i++) begin
      checks++; if (fall_t[i] - fall_t[i-1] != FRAME_CLKS) begin errors++; $display("FAIL %s frame_len[%0d] got=%0d exp=%0d", name, i, fall_t[i] - fall_t[i-1], FRAME_CLKS); end
    end
    checks++; if (dec_q.size() != nframes) begin errors++; $display("FAIL %s addr_frames got=%0d exp=%0d", name, dec_q.size(), nframes); end
    for (int i = 0; i < dec_q.size() && i < nframes; i++) begin
      checks++; if (dec_q[i] !== exp_addr[i]) begin errors++; $display("FAIL %s din_addr[%0d] got=%0d exp=%0d", name, i, dec_q[i], exp_addr[i]); end
    end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL %s valid_count got=%0d exp=%0d", name, got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s sample[%0d] got done/ch/data=%h exp=%h", name, i, got_q[i], exp_q[i]); end
      if (i + 1 < fall_t.size()) begin
        checks++; if (got_t[i] != fall_t[i+1] + PUB_OFS) begin errors++; $display("FAIL %s valid_time[%0d] got=%0d exp=%0d", name, i, got_t[i], fall_t[i+1] + PUB_OFS); end
      end
    end
    checks++; if (din_bad != 0) begin errors++; $display("FAIL %s din_outside_addr got=%0d exp=0", name, din_bad); end
    checks++; if (stray_done != 0) begin errors++; $display("FAIL %s stray_done got=%0d exp=0", name, stray_done); end
    checks++; if (cs !== 1'b1 || sclk !== 1'b1) begin errors++; $display("FAIL %s idle_lines got cs=%b sclk=%b exp 1 1", name, cs, sclk); end
  endtask

  task automatic test_zero_mask();
    int busy_seen = 0, cs_low_seen = 0;
    @(negedge clk);
    ch_mask = 8'h00;
    single = 1'b0;
    start = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
      if (cs !== 1'b1) cs_low_seen++;
    end
    start = 1'b0;
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL zero_mask_busy got=%0d cycles exp=0", busy_seen); end
    checks++; if (cs_low_seen != 0) begin errors++; $display("FAIL zero_mask_cs got=%0d cycles exp=0", cs_low_seen); end
  endtask

  task automatic test_reset_mid();
    int tmo, n_valid;
    got_q.delete(); got_t.delete(); fall_t.delete();
    for (int c = 0; c < 8; c++) conv[c] = 12'hA00 + 12'(c);
    @(negedge clk);
    ch_mask = 8'($urandom_range(1, 255));
    single = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tmo = 0;
    while (fall_t.size() < 2 && tmo < TMO) begin @(negedge clk); tmo++; end
    checks++; if (tmo >= TMO) begin errors++; $display("FAIL rst_mid_wait frames got=%0d exp=2", fall_t.size()); end
    repeat (2 + 8 * 4) @(negedge clk);
    n_valid = got_q.size();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_ptr = 3'd0;
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rst_mid_cs got=%b exp=1", cs); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL rst_mid_sclk got=%b exp=1", sclk); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", sample_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (sample !== 12'h000 || sample_ch !== 3'd0) begin errors++; $display("FAIL rst_mid_outputs got ch=%0d data=%h exp 0 000", sample_ch, sample); end
    repeat (150) @(negedge clk);
    checks++; if (got_q.size() != n_valid) begin errors++; $display("FAIL rst_mid_no_publish got=%0d exp=%0d", got_q.size(), n_valid); end
    checks++; if (fall_t.size() != 2) begin errors++; $display("FAIL rst_mid_no_restart got=%0d exp=2", fall_t.size()); end
  endtask

  task automatic test_clkdiv1();
    int         tmo;
    logic [2:0] p, a0, a1;
    logic [15:0] e0, e1;
    got2_q.delete(); got2_t.delete(); fall2_t.delete();
    sclk2_rises = 0;
    p  = 3'd0;
    a0 = next_ch(8'h12, p);
    a1 = next_ch(8'h12, a0 + 3'd1);
    e0 = {1'b0, next_ch(8'h12, a1 + 3'd1) == a0 ? a0 : a0, pattern2};
    e0 = {1'b0, a0, pattern2};
    e1 = {1'b1, a1, pattern2};
    @(negedge clk);
    ch_mask2 = 8'h12;
    single2 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    tmo = 0;
    while (busy2 !== 1'b0 && tmo < TMO) begin @(negedge clk); tmo++; end
    checks++; if (tmo >= TMO) begin errors++; $display("FAIL div1_idle_timeout busy=%b", busy2); end
    repeat (50) @(negedge clk);
    checks++; if (fall2_t.size() != 3) begin errors++; $display("FAIL div1_frames got=%0d exp=3", fall2_t.size()); end
    for (int i = 1; i < fall2_t.size(); i++) begin
      checks++; if (fall2_t[i] - fall2_t[i-1] != FRAME_CLKS2) begin errors++; $display("FAIL div1_frame_len[%0d] got=%0d exp=%0d", i, fall2_t[i] - fall2_t[i-1], FRAME_CLKS2); end
    end
    checks++; if (sclk2_rises != 48) begin errors++; $display("FAIL div1_sclk_rises got=%0d exp=48", sclk2_rises); end
    checks++; if (got2_q.size() != 2) begin errors++; $display("FAIL div1_valid_count got=%0d exp=2", got2_q.size()); end
    if (got2_q.size() >= 2) begin
      checks++; if (got2_q[0] !== e0) begin errors++; $display("FAIL div1_sample0 got=%h exp=%h", got2_q[0], e0); end
      checks++; if (got2_q[1] !== e1) begin errors++; $display("FAIL div1_sample1 got=%h exp=%h", got2_q[1], e1); end
      if (fall2_t.size() >= 3) begin
        checks++; if (got2_t[1] != fall2_t[2] + PUB_OFS2) begin errors++; $display("FAIL div1_valid_time got=%0d exp=%0d", got2_t[1], fall2_t[2] + PUB_OFS2); end
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 8; c++) conv[c] = 12'hA00 + 12'(c);
    test_reset();
    test_scan("single_05", 8'h05, 1'b1, 0, 1'b0);
    test_scan("cont_80", 8'h80, 1'b0, 5, 1'b0);
    test_zero_mask();
    test_scan("stop_f3", 8'($urandom_range(1, 255)), 1'b0, 3, 1'b1);
    for (int n = 0; n < 3; n++) test_scan("rand_single", 8'($urandom_range(1, 255)), 1'b1, 0, 1'b1);
    test_reset_mid();
    test_scan("after_reset", 8'($urandom_range(1, 255)), 1'b1, 0, 1'b1);
    test_clkdiv1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
